atan_coeff_loader: RTL and testbench

//  Sits around dynamic coefficient generation: issues the atan(2^0) seed to the upstream generator, then

---
 rtl/atan_pkg.sv | 15 +
 rtl/atan_bank_regfile.sv | 49 ++++
 rtl/atan_coeff_loader.sv | 110 +++++++++++
 tb/tb_atan_coeff_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/atan_pkg.sv
// Shared definitions for the atan coefficient loader: FSM encoding
// and fixed-point constants (1.0 = 2^12).
package atan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEED,
        ST_LOAD,
        ST_READY
    } state_t;

    localparam int FXP_ONE       = 4096;
    localparam int ATAN0_DEFAULT = 3217;

endpackage

// File: rtl/atan_bank_regfile.sv
// N_PE x DATA_WIDTH write-indexed coefficient bank with flat output bus.
// Optional registered read port when ATAN_LOADER_RDPORT_EN is defined.
module atan_bank_regfile #(
    parameter int N_PE       = 16,
    parameter int DATA_WIDTH = 18,
    parameter int AW         = $clog2(N_PE)
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_we,
    input  logic [AW-1:0]              i_waddr,
    input  logic [DATA_WIDTH-1:0]      i_wdata,
`ifdef ATAN_LOADER_RDPORT_EN
    input  logic [AW-1:0]              i_rd_addr,
    output logic [DATA_WIDTH-1:0]      o_rd_data,
`endif
    output logic [N_PE*DATA_WIDTH-1:0] o_bus
);

    logic [DATA_WIDTH-1:0] bank [N_PE];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int k = 0; k < N_PE; k++) begin
                bank[k] <= '0;
            end
        end else if (i_we) begin
            bank[i_waddr] <= i_wdata;
        end
    end

    for (genvar g = 0; g < N_PE; g++) begin : g_bus
        assign o_bus[g*DATA_WIDTH +: DATA_WIDTH] = bank[g];
    end

`ifdef ATAN_LOADER_RDPORT_EN
    // Addresses past the bank depth read as zero
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_rd_data <= '0;
        end else if (int'(i_rd_addr) < N_PE) begin
            o_rd_data <= bank[i_rd_addr];
        end else begin
            o_rd_data <= '0;
        end
    end
`endif

endmodule

// File: rtl/atan_coeff_loader.sv
// Seeds the atan coefficient generator and captures its stream into a bank.
// ATAN_LOADER_RDPORT_EN adds a registered random-access read port.
module atan_coeff_loader
    import atan_pkg::*;
#(
    parameter int N_PE       = 16,
    parameter int DATA_WIDTH = 18,
    parameter int ATAN0      = ATAN0_DEFAULT
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic                         i_load_req,
    output logic [DATA_WIDTH-1:0]        o_seed_data,
    output logic                         o_seed_valid,
    input  logic [DATA_WIDTH-1:0]        i_coeff_data,
    input  logic                         i_coeff_valid,
    input  logic                         i_coeff_done,
`ifdef ATAN_LOADER_RDPORT_EN
    input  logic [$clog2(N_PE)-1:0]      i_rd_addr,
    output logic [DATA_WIDTH-1:0]        o_rd_data,
`endif
    output logic [N_PE*DATA_WIDTH-1:0]   o_coeff_bus,
    output logic                         o_bank_valid,
    output logic                         o_busy,
    output logic                         o_err
);

    localparam int IW = $clog2(N_PE) + 1;
    localparam int AW = IW - 1;
    localparam logic [IW-1:0] FULL = IW'(N_PE);

    state_t        state;
    logic [IW-1:0] idx;
    logic          wr_en;
    logic          over;
    logic [IW-1:0] cnt_next;

    // Count includes a write landing in the same cycle as done
    always_comb begin
        wr_en    = (state == ST_LOAD) && i_coeff_valid && (idx < FULL);
        over     = (state == ST_LOAD) && i_coeff_valid && !(idx < FULL);
        cnt_next = idx + IW'(wr_en);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= ST_IDLE;
            idx          <= '0;
            o_seed_data  <= '0;
            o_seed_valid <= 1'b0;
            o_bank_valid <= 1'b0;
            o_busy       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_seed_valid <= 1'b0;
            o_seed_data  <= '0;
            case (state)
                ST_IDLE, ST_READY: begin
                    if (i_load_req) begin
                        state        <= ST_SEED;
                        o_seed_valid <= 1'b1;
                        o_seed_data  <= DATA_WIDTH'(ATAN0);
                        o_bank_valid <= 1'b0;
                        o_err        <= 1'b0;
                        o_busy       <= 1'b1;
                        idx          <= '0;
                    end
                end
                ST_SEED: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    idx <= cnt_next;
                    if (over) begin
                        o_err <= 1'b1;
                    end
                    if (i_coeff_done) begin
                        o_busy <= 1'b0;
                        if (cnt_next == FULL && !o_err && !over) begin
                            state        <= ST_READY;
                            o_bank_valid <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            o_err <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    atan_bank_regfile #(
        .N_PE       (N_PE),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_bank (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_we       (wr_en),
        .i_waddr    (idx[AW-1:0]),
        .i_wdata    (i_coeff_data),
`ifdef ATAN_LOADER_RDPORT_EN
        .i_rd_addr  (i_rd_addr),
        .o_rd_data  (o_rd_data),
`endif
        .o_bus      (o_coeff_bus)
    );

endmodule

// File: tb/tb_atan_coeff_loader.sv
// Randomised bench for atan_coeff_loader against a transaction-level model.
// Define ATAN_LOADER_RDPORT_EN to also exercise the read port.
module tb_atan_coeff_loader;

    localparam int N  = 16;
    localparam int DW = 18;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            load_req = 1'b0;
    logic            cv = 1'b0;
    logic            cdone = 1'b0;
    logic [DW-1:0]   cdata = '0;
    logic [DW-1:0]   seed_data;
    logic            seed_valid;
    logic [N*DW-1:0] bus;
    logic            bank_valid;
    logic            busy;
    logic            err;
`ifdef ATAN_LOADER_RDPORT_EN
    logic [3:0]      rd_addr = '0;
    logic [DW-1:0]   rd_data;
    logic [DW-1:0]   m_rd;
`endif

    atan_coeff_loader dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_load_req    (load_req),
        .o_seed_data   (seed_data),
        .o_seed_valid  (seed_valid),
        .i_coeff_data  (cdata),
        .i_coeff_valid (cv),
        .i_coeff_done  (cdone),
`ifdef ATAN_LOADER_RDPORT_EN
        .i_rd_addr     (rd_addr),
        .o_rd_data     (rd_data),
`endif
        .o_coeff_bus   (bus),
        .o_bank_valid  (bank_valid),
        .o_busy        (busy),
        .o_err         (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int seed_pulses = 0;
    bit rd_rand = 1;

    // Model: what the loader must show, tracked per transaction phase
    logic [DW-1:0] mbank [N];
    bit m_valid, m_err, m_busy, m_seed, m_loading;
    int m_cnt;

    task automatic chk(input string nm, input logic [N*DW-1:0] act,
                       input logic [N*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N*DW-1:0] mbus();
        logic [N*DW-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = mbank[k];
        return r;
    endfunction

    function automatic logic [DW-1:0] atan_ref(int k);
        real v;
        v = $atan(2.0 ** (-k)) * 4096.0;
        return DW'(int'(v));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) mbank[k] = '0;
        m_valid = 0; m_err = 0; m_busy = 0; m_seed = 0;
        m_loading = 0; m_cnt = 0;
`ifdef ATAN_LOADER_RDPORT_EN
        m_rd = '0;
`endif
    endtask

    task automatic step(input bit ld, input bit v, input logic [DW-1:0] d,
                        input bit dn);
        load_req = ld; cv = v; cdata = d; cdone = dn;
        @(posedge clk);
        if (!rstn) begin
            model_reset();
        end else begin
`ifdef ATAN_LOADER_RDPORT_EN
            m_rd = (int'(rd_addr) < N) ? mbank[rd_addr] : '0;
`endif
            if (m_seed) begin
                m_seed = 0;
                m_loading = 1;
            end else if (m_loading) begin
                if (v) begin
                    if (m_cnt < N) begin
                        mbank[m_cnt] = d;
                        m_cnt++;
                    end else begin
                        m_err = 1;
                    end
                end
                if (dn) begin
                    m_loading = 0;
                    m_busy = 0;
                    if (!m_err && m_cnt == N) m_valid = 1;
                    else m_err = 1;
                end
            end else if (ld) begin
                m_seed = 1; m_busy = 1; m_valid = 0; m_err = 0; m_cnt = 0;
            end
        end
        #1;
`ifdef ATAN_LOADER_RDPORT_EN
        if (rd_rand) rd_addr = 4'($urandom);
`endif
        load_req = 0; cv = 0; cdone = 0;
    endtask

    always @(negedge clk) begin
        chk("bus", bus, mbus());
        chk("bank_valid", bank_valid, m_valid);
        chk("err", err, m_err);
        chk("busy", busy, m_busy);
        chk("seed_valid", seed_valid, m_seed);
        if (seed_valid) begin
            seed_pulses++;
            chk("seed_data", seed_data, 3217);
        end
`ifdef ATAN_LOADER_RDPORT_EN
        chk("rd_data", rd_data, m_rd);
`endif
    end

    // One load transaction: request, seed cycle, beats, done
    task automatic run_load(input int nb, input bit dn_last,
                            input bit rnd, input bit noise);
        logic [DW-1:0] d;
        bit last;
        step(1, 0, '0, 0);
        step(noise ? 1'($urandom) : 1'b0, 0, '0, 0);
        for (int b = 0; b < nb; b++) begin
            while (noise && $urandom_range(3) == 0)
                step(1'($urandom), 0, DW'($urandom), 0);
            d = rnd ? DW'($urandom) : atan_ref(b < N ? b : 0);
            last = (b == nb - 1) && dn_last;
            step(noise ? 1'($urandom) : 1'b0, 1, d, last);
        end
        if (!dn_last || nb == 0) step(0, 0, '0, 1);
        step(0, 0, '0, 0);
    endtask

    initial begin
        model_reset();
        step(0, 0, '0, 0);
        step(0, 0, '0, 0);
        chk("rst_bus", bus, '0);
        chk("rst_busy", busy, 0);
        chk("rst_seed", seed_valid, 0);
        rstn = 1'b1;
        step(0, 0, '0, 0);

        // Full nominal load
        seed_pulses = 0;
        run_load(16, 1, 0, 0);
        chk("t1_seed_pulses", seed_pulses, 1);
        chk("t1_bus0", bus[0*DW +: DW], 3217);
        chk("t1_bus1", bus[1*DW +: DW], 1899);
        chk("t1_bus5", bus[5*DW +: DW], 128);
        chk("t1_bus15", bus[15*DW +: DW], 0);
        chk("t1_valid", bank_valid, 1);
        chk("t1_err", err, 0);

        // Short stream
        run_load(15, 0, 1, 0);
        chk("t2_err", err, 1);
        chk("t2_valid", bank_valid, 0);
        chk("t2_busy", busy, 0);

        // Overlong stream
        run_load(17, 1, 1, 0);
        chk("t3_err", err, 1);
        chk("t3_valid", bank_valid, 0);

        // Recovery, then reload from READY
        run_load(16, 0, 0, 0);
        chk("t4_valid", bank_valid, 1);
        chk("t4_err", err, 0);
        step(1, 0, '0, 0);
        chk("t4_drop", bank_valid, 0);
        chk("t4_busy", busy, 1);
        step(0, 0, '0, 0);
        for (int b = 0; b < N; b++) step(0, 1, atan_ref(b), b == N - 1);
        step(0, 0, '0, 0);
        chk("t4_reload_valid", bank_valid, 1);

        // Async reset part way through a load
        step(1, 0, '0, 0);
        step(0, 0, '0, 0);
        for (int b = 0; b < 7; b++) step(0, 1, DW'($urandom), 0);
        cv = 1; cdata = DW'($urandom);
        #2 rstn = 1'b0;
        #1;
        model_reset();
        chk("t5_bus", bus, '0);
        chk("t5_busy", busy, 0);
        chk("t5_valid", bank_valid, 0);
        step(0, 0, '0, 0);
        step(0, 0, '0, 0);
        rstn = 1'b1;
        run_load(16, 1, 0, 0);
        chk("t5_after_valid", bank_valid, 1);

`ifdef ATAN_LOADER_RDPORT_EN
        rd_rand = 0;
        rd_addr = 4'd0;
        step(0, 0, '0, 0);
        chk("t6_rd0", rd_data, 3217);
        rd_addr = 4'd5;
        step(0, 0, '0, 0);
        chk("t6_rd5", rd_data, 128);
        rd_rand = 1;
`endif

        // Randomised loads with gaps and ignored requests
        for (int t = 0; t < 40; t++) begin
            run_load($urandom_range(14, 18), 1'($urandom), 1, 1);
            if ($urandom_range(3) == 0) step(0, 0, '0, 0);
        end

        step(0, 0, '0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
